// File: rtl/rv32i_mem_port_pkg.sv
// Shared definitions for the rv32i memory port: width codes, FSM states and helpers.
package rv32i_mem_port_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LO   = 2'b01,
        ST_HI   = 2'b10,
        ST_RESP = 2'b11
    } state_e;

    function automatic logic funct3_ok(input logic write, input logic [2:0] f3);
        if (write) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // Extends either the low byte or the full halfword; signed_en = 0 zero-extends.
    function automatic logic [31:0] sign_ext(input logic [15:0] val,
                                             input logic        is_byte,
                                             input logic        signed_en);
        logic msb;
        msb = signed_en & (is_byte ? val[7] : val[15]);
        if (is_byte) begin
            return {{24{msb}}, val[7:0]};
        end
        return {{16{msb}}, val};
    endfunction

endpackage

// File: rtl/rv32i_lane_align.sv
// Combinational lane steering: read byte/half select with extension, write byte enables
// and byte replication onto the 16-bit bus.
module rv32i_lane_align
    import rv32i_mem_port_pkg::*;
(
    input  logic        write_i,
    input  logic [2:0]  funct3_i,
    input  logic        lane_i,
    input  logic        hi_i,
    input  logic [31:0] rraw_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic [1:0]  be_o,
    output logic [15:0] wdata_o
);

    logic [7:0] rbyte;

    always_comb begin
        rdata_o = '0;
        be_o    = '0;
        wdata_o = '0;
        rbyte   = lane_i ? rraw_i[15:8] : rraw_i[7:0];
        case (funct3_i[1:0])
            SZ_BYTE: begin
                rdata_o = sign_ext({8'h00, rbyte}, 1'b1, !funct3_i[2]);
                be_o    = lane_i ? 2'b10 : 2'b01;
                wdata_o = {2{wdata_i[7:0]}};
            end
            SZ_HALF: begin
                rdata_o = sign_ext(rraw_i[15:0], 1'b0, !funct3_i[2]);
                be_o    = 2'b11;
                wdata_o = wdata_i[15:0];
            end
            SZ_WORD: begin
                rdata_o = rraw_i;
                be_o    = 2'b11;
                wdata_o = hi_i ? wdata_i[31:16] : wdata_i[15:0];
            end
            default: ;
        endcase
        if (!write_i) begin
            wdata_o = '0;
        end
    end

endmodule

// File: rtl/rv32i_mem_port.sv
// Splits 32-bit load/store/fetch requests into one or two 16-bit bus cycles.
// Build option: RV32I_MISALIGNED_TRAP_EN reports misaligned half/word as an error.
//
//  state   | meaning
//  IDLE    | ready; latches an accepted request
//  LO      | strobe on the low halfword, wait for ack
//  HI      | strobe on the high halfword (word accesses only)
//  RESP    | one-cycle response pulse
module rv32i_mem_port
    import rv32i_mem_port_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int BUS_W  = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [XLEN-1:0]   req_wdata_i,
    output logic              rsp_valid_o,
    output logic [XLEN-1:0]   rsp_rdata_o,
    output logic              rsp_err_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic              bus_rd_o,
    output logic              bus_wr_o,
    output logic [1:0]        bus_be_o,
    output logic [BUS_W-1:0]  bus_wdata_o,
    input  logic [BUS_W-1:0]  bus_rdata_i,
    input  logic              bus_ack_i
);

    state_e              state_q, state_d;
    logic                write_q;
    logic [2:0]          funct3_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [XLEN-1:0]     wdata_q;
    logic [BUS_W-1:0]    lo_q;
    logic [XLEN-1:0]     rdata_q;
    logic                err_q;

    logic                accept;
    logic                bad_f3;
    logic                misal;
    logic                req_err;
    logic [ADDR_W-1:0]   addr_acc;
    logic                strobe;
    logic                is_word_q;
    logic [XLEN-1:0]     rraw;
    logic [XLEN-1:0]     align_rdata;
    logic [1:0]          align_be;
    logic [BUS_W-1:0]    align_wdata;
    logic [ADDR_W-1:0]   base_addr;

    assign accept    = req_valid_i && (state_q == ST_IDLE);
    assign bad_f3    = !funct3_ok(req_write_i, req_funct3_i);
    assign req_err   = bad_f3 || misal;
    assign strobe    = (state_q == ST_LO) || (state_q == ST_HI);
    assign is_word_q = (funct3_q[1:0] == SZ_WORD);
    assign base_addr = {addr_q[ADDR_W-1:1], 1'b0};

`ifdef RV32I_MISALIGNED_TRAP_EN
    assign misal = ((req_funct3_i[1:0] == SZ_HALF) && req_addr_i[0]) ||
                   ((req_funct3_i[1:0] == SZ_WORD) && (req_addr_i[1:0] != 2'b00));
    assign addr_acc = req_addr_i;
`else
    assign misal = 1'b0;
    always_comb begin
        addr_acc = req_addr_i;
        if (req_funct3_i[1:0] == SZ_HALF) begin
            addr_acc[0] = 1'b0;
        end
        if (req_funct3_i[1:0] == SZ_WORD) begin
            addr_acc[1:0] = 2'b00;
        end
    end
`endif

    // The high half is only meaningful on the HI ack, when lo_q already holds the low half.
    always_comb begin
        rraw = {{(XLEN-BUS_W){1'b0}}, bus_rdata_i};
        if (state_q == ST_HI) begin
            rraw = {bus_rdata_i, lo_q};
        end
    end

    rv32i_lane_align u_align (
        .write_i  (write_q),
        .funct3_i (funct3_q),
        .lane_i   (addr_q[0]),
        .hi_i     (state_q == ST_HI),
        .rraw_i   (rraw),
        .wdata_i  (wdata_q),
        .rdata_o  (align_rdata),
        .be_o     (align_be),
        .wdata_o  (align_wdata)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = req_err ? ST_RESP : ST_LO;
            ST_LO:   if (bus_ack_i) state_d = is_word_q ? ST_HI : ST_RESP;
            ST_HI:   if (bus_ack_i) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = (state_q == ST_IDLE);
        rsp_valid_o = (state_q == ST_RESP);
        rsp_err_o   = (state_q == ST_RESP) && err_q;
        rsp_rdata_o = (state_q == ST_RESP) ? rdata_q : '0;
        bus_addr_o  = '0;
        bus_rd_o    = 1'b0;
        bus_wr_o    = 1'b0;
        bus_be_o    = '0;
        bus_wdata_o = '0;
        if (strobe) begin
            bus_addr_o  = (state_q == ST_HI) ? base_addr + ADDR_W'(2) : base_addr;
            bus_rd_o    = !write_q;
            bus_wr_o    = write_q;
            bus_be_o    = align_be;
            bus_wdata_o = align_wdata;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            write_q  <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            lo_q     <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                write_q  <= req_write_i;
                funct3_q <= req_funct3_i;
                addr_q   <= addr_acc;
                wdata_q  <= req_wdata_i;
                rdata_q  <= '0;
                err_q    <= req_err;
            end
            if ((state_q == ST_LO) && bus_ack_i) begin
                lo_q <= bus_rdata_i;
                if (!write_q && !is_word_q) begin
                    rdata_q <= align_rdata;
                end
            end
            if ((state_q == ST_HI) && bus_ack_i && !write_q) begin
                rdata_q <= align_rdata;
            end
        end
    end

endmodule
